// File: rtl/utils_pkg.sv
// Shared constants for the stream demux: default word width and channel indices.
package utils_pkg;

    localparam int DATA_W_DEF = 5;
    localparam logic CH0 = 1'b0;
    localparam logic CH1 = 1'b1;

    // Occupancy decode for (log2(DEPTH)+1)-bit wrapping pointers.
    function automatic logic ptr_full(input logic [31:0] wr_ptr, input logic [31:0] rd_ptr, input int aw);
        logic [31:0] diff_s;
        diff_s = wr_ptr ^ rd_ptr;
        return (diff_s[aw] == 1'b1) && ((diff_s & ((32'd1 << aw) - 32'd1)) == 32'd0);
    endfunction

endpackage

// File: rtl/demux_fifo_channel.sv
// One output channel of the demux: small FIFO with valid/ready pop side and an
// accepted-word counter.
module demux_fifo_channel
    import utils_pkg::*;
#(
    parameter int DATA_W = 5,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    output logic              full,
    input  logic              pop_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  cnt
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]                   wr_ptr_r;
    logic [AW:0]                   rd_ptr_r;
    logic [DEPTH-1:0][DATA_W-1:0]  mem_r;
    logic [CNT_W-1:0]              cnt_r;
    logic                          full_s;
    logic                          empty_s;
    logic                          do_push_s;
    logic                          do_pop_s;

    // Occupancy flags and qualified push/pop strobes.
    always_comb begin
        full_s    = ptr_full(32'(wr_ptr_r), 32'(rd_ptr_r), AW);
        empty_s   = (wr_ptr_r == rd_ptr_r);
        do_push_s = push && !full_s;
        do_pop_s  = !empty_s && pop_ready;
    end

    // Pointer, storage and counter state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
            mem_r    <= {(DEPTH*DATA_W){1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r[AW-1:0]] <= push_data;
                wr_ptr_r                <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
                cnt_r                   <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
        end
    end

    // Head word straight from storage, masked to zero when empty.
    always_comb begin
        full      = full_s;
        out_valid = !empty_s;
        cnt       = cnt_r;
        if (empty_s) begin
            out_data = {DATA_W{1'b0}};
        end else begin
            out_data = mem_r[rd_ptr_r[AW-1:0]];
        end
    end

endmodule

// File: rtl/stream_demux_5to10.sv
// Routes one valid/ready word stream to two independent FIFO channels,
// chosen per word by select.
module stream_demux_5to10
    import utils_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              select,
    input  logic [DATA_W-1:0] in_data,
    output logic              out0_valid,
    input  logic              out0_ready,
    output logic [DATA_W-1:0] out0_data,
    output logic              out1_valid,
    input  logic              out1_ready,
    output logic [DATA_W-1:0] out1_data,
    output logic [CNT_W-1:0]  cnt0,
    output logic [CNT_W-1:0]  cnt1
);

    logic [1:0] full_s;
    logic [1:0] push_s;
    logic       accept_s;

    // in_ready looks only at the selected channel's fullness, never at in_valid or the consumers.
    always_comb begin
        in_ready = 1'b0;
        accept_s = 1'b0;
        push_s   = 2'b00;
        if (rst_n) begin
            in_ready = (select == CH1) ? !full_s[1] : !full_s[0];
        end else begin
            in_ready = 1'b0;
        end
        accept_s = in_valid && in_ready;
        case (select)
            CH0:     push_s = {1'b0, accept_s};
            CH1:     push_s = {accept_s, 1'b0};
            default: push_s = 2'b00;
        endcase
    end

    demux_fifo_channel #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) u_ch0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_s[0]),
        .push_data (in_data),
        .full      (full_s[0]),
        .pop_ready (out0_ready),
        .out_valid (out0_valid),
        .out_data  (out0_data),
        .cnt       (cnt0)
    );

    demux_fifo_channel #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) u_ch1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_s[1]),
        .push_data (in_data),
        .full      (full_s[1]),
        .pop_ready (out1_ready),
        .out_valid (out1_valid),
        .out_data  (out1_data),
        .cnt       (cnt1)
    );

endmodule

// File: tb/tb_stream_demux_5to10.sv
// Randomised and directed bench for stream_demux_5to10 against a queue-based model.
module tb_stream_demux_5to10;

    localparam int DEPTH = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       select = 1'b0;
    logic [4:0] in_data = 5'd0;
    logic       out0_valid;
    logic       out0_ready = 1'b0;
    logic [4:0] out0_data;
    logic       out1_valid;
    logic       out1_ready = 1'b0;
    logic [4:0] out1_data;
    logic [7:0] cnt0;
    logic [7:0] cnt1;

    int checks = 0;
    int errors = 0;

    logic [4:0] q0[$];
    logic [4:0] q1[$];
    logic [7:0] cm0 = 8'd0;
    logic [7:0] cm1 = 8'd0;

    stream_demux_5to10 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .select     (select),
        .in_data    (in_data),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out0_data  (out0_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready),
        .out1_data  (out1_data),
        .cnt0       (cnt0),
        .cnt1       (cnt1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Reference model: per-channel queues, pop of the old head then push of the new word.
    always @(posedge clk or negedge rst_n) begin
        bit p0, p1, acc;
        if (!rst_n) begin
            q0.delete();
            q1.delete();
            cm0 = 8'd0;
            cm1 = 8'd0;
        end else begin
            p0  = (q0.size() > 0) && out0_ready;
            p1  = (q1.size() > 0) && out1_ready;
            acc = in_valid && (select ? (q1.size() < DEPTH) : (q0.size() < DEPTH));
            if (p0) void'(q0.pop_front());
            if (p1) void'(q1.pop_front());
            if (acc) begin
                if (select) begin
                    q1.push_back(in_data);
                    cm1 = cm1 + 8'd1;
                end else begin
                    q0.push_back(in_data);
                    cm0 = cm0 + 8'd1;
                end
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        logic       er;
        logic [4:0] e0, e1;
        er = rst_n && (select ? (q1.size() < DEPTH) : (q0.size() < DEPTH));
        e0 = (q0.size() > 0) ? q0[0] : 5'd0;
        e1 = (q1.size() > 0) ? q1[0] : 5'd0;
        chk("in_ready", 32'(in_ready), 32'(er));
        chk("out0_valid", 32'(out0_valid), 32'(q0.size() > 0));
        chk("out1_valid", 32'(out1_valid), 32'(q1.size() > 0));
        chk("out0_data", 32'(out0_data), 32'(e0));
        chk("out1_data", 32'(out1_data), 32'(e1));
        chk("cnt0", 32'(cnt0), 32'(cm0));
        chk("cnt1", 32'(cnt1), 32'(cm1));
    end

    task automatic reset_pulse();
        #2 rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        cycle();
    endtask

    task automatic push(input logic sel, input logic [4:0] d);
        in_valid = 1'b1;
        select   = sel;
        in_data  = d;
        cycle();
        in_valid = 1'b0;
    endtask

    initial begin
        cycle();
        cycle();
        chk("reset_out0_valid", 32'(out0_valid), 32'd0);
        chk("reset_cnt0", 32'(cnt0), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b1;
        cycle();

        // Reset in the middle of a transfer.
        out0_ready = 1'b0;
        push(1'b0, 5'h03);
        push(1'b0, 5'h07);
        chk("mid_head", 32'(out0_data), 32'h03);
        chk("mid_cnt0", 32'(cnt0), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_out0_valid", 32'(out0_valid), 32'd0);
        chk("rst_out0_data", 32'(out0_data), 32'd0);
        chk("rst_cnt0", 32'(cnt0), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        cycle();
        rst_n = 1'b1;
        cycle();
        out0_ready = 1'b1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        cycle();
        chk("no_stale", 32'(out0_valid), 32'd0);

        // Routing to both channels.
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        in_valid = 1'b1; select = 1'b0; in_data = 5'h15;
        cycle();
        chk("route_d0", 32'(out0_data), 32'h15);
        chk("route_c0", 32'(cnt0), 32'd1);
        select = 1'b1; in_data = 5'h0A;
        cycle();
        in_valid = 1'b0;
        chk("route_d1", 32'(out1_data), 32'h0A);
        chk("route_c1", 32'(cnt1), 32'd1);
        chk("route_v0_popped", 32'(out0_valid), 32'd0);
        cycle();

        // Channel 1 full does not block channel 0.
        out1_ready = 1'b0;
        out0_ready = 1'b0;
        push(1'b1, 5'h01);
        push(1'b1, 5'h02);
        select = 1'b1;
        #1;
        chk("full1_in_ready", 32'(in_ready), 32'd0);
        select = 1'b0;
        #1;
        chk("ch0_ready_while_ch1_full", 32'(in_ready), 32'd1);
        push(1'b0, 5'h1F);
        chk("ch0_data_1f", 32'(out0_data), 32'h1F);
        out0_ready = 1'b1; out1_ready = 1'b1;
        repeat (3) cycle();

        // Simultaneous push and pop on one channel.
        out0_ready = 1'b0;
        push(1'b0, 5'h04);
        out0_ready = 1'b1;
        push(1'b0, 5'h05);
        chk("pp_head", 32'(out0_data), 32'h05);
        chk("pp_occ", 32'(q0.size()), 32'd1);
        out0_ready = 1'b0;
        push(1'b0, 5'h06);
        out0_ready = 1'b1;
        in_valid = 1'b1; select = 1'b0; in_data = 5'h07;
        #1;
        chk("full_push_refused_ready", 32'(in_ready), 32'd0);
        cycle();
        in_valid = 1'b0;
        chk("full_push_refused_head", 32'(out0_data), 32'h06);
        cycle();
        chk("full_push_refused_empty", 32'(out0_valid), 32'd0);

        // Ordered stream with random backpressure.
        for (int i = 0; i < 32; i++) begin
            int w;
            bit done;
            w = 0;
            done = 1'b0;
            in_valid = 1'b1;
            select   = i[0];
            in_data  = i[4:0];
            while (!done && w < 200) begin
                out0_ready = 1'($urandom_range(0, 1));
                out1_ready = 1'($urandom_range(0, 1));
                done = in_ready;
                cycle();
                w++;
            end
            if (!done) chk("order_accept_timeout", 32'd0, 32'd1);
        end
        in_valid = 1'b0;

        // Fully random traffic.
        for (int i = 0; i < 400; i++) begin
            in_valid   = 1'($urandom_range(0, 1));
            select     = 1'($urandom_range(0, 1));
            in_data    = 5'($urandom_range(0, 31));
            out0_ready = 1'($urandom_range(0, 1));
            out1_ready = 1'($urandom_range(0, 1));
            cycle();
        end
        in_valid = 1'b0;
        out0_ready = 1'b1;
        out1_ready = 1'b1;
        repeat (4) cycle();
        chk("drained0", 32'(out0_valid), 32'd0);
        chk("drained1", 32'(out1_valid), 32'd0);

        // Counter wrap on channel 0.
        reset_pulse();
        in_valid = 1'b1;
        select = 1'b0;
        for (int i = 0; i < 255; i++) begin
            in_data = 5'(i);
            cycle();
        end
        chk("cnt0_255", 32'(cnt0), 32'd255);
        in_data = 5'h11;
        cycle();
        in_valid = 1'b0;
        chk("cnt0_wrap", 32'(cnt0), 32'd0);
        chk("cnt1_unchanged", 32'(cnt1), 32'd0);
        repeat (3) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
